// File: rtl/fb_rect_fill.sv
// fb_rect_fill: fills an axis-aligned rectangle of a linear framebuffer
// with a single colour, one pixel write per cycle in raster order.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o command handshake
//   cmd_x0_i .. cmd_y1_i      inclusive rectangle corners
//   cmd_color_i               packed {R,G,B} fill colour
//   wr_en_o/wr_addr_o/wr_data_o  framebuffer write port (no back-pressure)
//   busy_o                    engine not idle
//   done_o / err_o            one-cycle completion / rejection pulses
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready_o high
// CHECK  | validate latched command, preload first pixel
// FILL   | one write per cycle, raster order
// DONE   | done_o pulse, return to IDLE
module fb_rect_fill #(
    parameter int VGA_WIDTH       = 640,
    parameter int VGA_HEIGHT      = 480,
    parameter int VGA_COLOR_DEPTH = 4,
    parameter int BUFFER_WIDTH    = VGA_COLOR_DEPTH * 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [9:0]              cmd_x0_i,
    input  logic [9:0]              cmd_y0_i,
    input  logic [9:0]              cmd_x1_i,
    input  logic [9:0]              cmd_y1_i,
    input  logic [BUFFER_WIDTH-1:0] cmd_color_i,
    output logic                    wr_en_o,
    output logic [BUFFER_WIDTH-1:0] wr_data_o,
    output logic [18:0]             wr_addr_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [10:0] WIDTH_L  = 11'(VGA_WIDTH);
    localparam logic [10:0] HEIGHT_L = 11'(VGA_HEIGHT);
    localparam logic [18:0] WIDTH_A  = 19'(VGA_WIDTH);

    // Constant-coefficient multiply by the framebuffer width as a sum of
    // shifted copies of the row index (640 -> (row<<9)+(row<<7)).
    function automatic logic [18:0] times_width(input logic [9:0] row);
        logic [18:0] acc;
        acc = '0;
        for (int i = 0; i < 19; i++) begin
            if (WIDTH_A[i]) begin
                acc = acc + (19'(row) << i);
            end
        end
        return acc;
    endfunction

    state_t                  state_q, state_d;
    logic [9:0]              x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [BUFFER_WIDTH-1:0] color_q, color_d;
    logic [9:0]              x_q, x_d, y_q, y_d;
    logic [18:0]             row_base_q, row_base_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    wr_en_q, wr_en_d;
    logic [18:0]             wr_addr_q, wr_addr_d;
    logic [BUFFER_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    cmd_ok;
    logic [18:0]             first_base;
    logic                    last_col;
    logic                    last_row;

    assign cmd_ok = (x0_q <= x1_q) && ({1'b0, x1_q} < WIDTH_L) &&
                    (y0_q <= y1_q) && ({1'b0, y1_q} < HEIGHT_L);
    assign first_base = times_width(y0_q);
    assign last_col   = (x_q == x1_q);
    assign last_row   = (y_q == y1_q);

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        color_d    = color_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    x0_d    = cmd_x0_i;
                    y0_d    = cmd_y0_i;
                    x1_d    = cmd_x1_i;
                    y1_d    = cmd_y1_i;
                    color_d = cmd_color_i;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cmd_ok) begin
                    x_d        = x0_q;
                    y_d        = y0_q;
                    row_base_d = first_base;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = first_base + 19'(x0_q);
                    wr_data_d  = color_q;
                    state_d    = S_FILL;
                end else begin
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                // x_q/y_q name the pixel currently on the write port; the
                // registered outputs are loaded with the following pixel.
                if (last_col && last_row) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (last_col) begin
                    x_d        = x0_q;
                    y_d        = y_q + 10'd1;
                    row_base_d = row_base_q + WIDTH_A;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = row_base_q + WIDTH_A + 19'(x0_q);
                    wr_data_d  = color_q;
                end else begin
                    x_d       = x_q + 10'd1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = row_base_q + 19'(x_q) + 19'd1;
                    wr_data_d = color_q;
                end
            end
            S_DONE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            color_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            color_q    <= color_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Ready is masked while reset is held so a requester never sees a
    // handshake that the reset branch would swallow.
    assign cmd_ready_o = ready_q & ~rst;
    assign busy_o      = busy_q;
    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
module tb_fb_rect_fill;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [9:0]  cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i;
    logic [11:0] cmd_color_i;
    logic        wr_en_o;
    logic [11:0] wr_data_o;
    logic [18:0] wr_addr_o;
    logic        busy_o, done_o, err_o;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;
    int exp_addr_q[$];
    int exp_data_q[$];

    always #5 clk = ~clk;

    fb_rect_fill dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_x0_i    (cmd_x0_i),
        .cmd_y0_i    (cmd_y0_i),
        .cmd_x1_i    (cmd_x1_i),
        .cmd_y1_i    (cmd_y1_i),
        .cmd_color_i (cmd_color_i),
        .wr_en_o     (wr_en_o),
        .wr_data_o   (wr_data_o),
        .wr_addr_o   (wr_addr_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected raster-order writes of a rectangle.
    task automatic push_rect(input int x0, input int y0, input int x1, input int y1, input int col);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                exp_addr_q.push_back(y * 640 + x);
                exp_data_q.push_back(col);
            end
        end
    endtask

    // Scoreboard: every observed write pops one expected entry.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_en_o === 1'b1) begin
                if (exp_addr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL unexpected_write: observed addr %0d expected no write", wr_addr_o);
                end else begin
                    int ea, ed;
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    chk("wr_addr", 32'(wr_addr_o), 32'(ea));
                    chk("wr_data", 32'(wr_data_o), 32'(ed));
                end
            end else begin
                chk("idle_addr", 32'(wr_addr_o), 32'd0);
                chk("idle_data", 32'(wr_data_o), 32'd0);
            end
        end
    end

    task automatic drive_cmd(input int x0, input int y0, input int x1, input int y1, input int col);
        cmd_x0_i    = 10'(x0);
        cmd_y0_i    = 10'(y0);
        cmd_x1_i    = 10'(x1);
        cmd_y1_i    = 10'(y1);
        cmd_color_i = 12'(col);
        cmd_valid_i = 1'b1;
    endtask

    // Drives a command and completes its handshake; returns in cycle T+1.
    task automatic send(input int x0, input int y0, input int x1, input int y1, input int col);
        drive_cmd(x0, y0, x1, y1, col);
        chk("ready_at_hs", 32'(cmd_ready_o), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    // Cycle-exact checks after a valid handshake: CHECK, n writes, DONE, IDLE.
    task automatic expect_fill(input int n);
        @(negedge clk);
        chk("check_busy", 32'(busy_o), 32'd1);
        chk("check_ready", 32'(cmd_ready_o), 32'd0);
        chk("check_wr_en", 32'(wr_en_o), 32'd0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("fill_wr_en", 32'(wr_en_o), 32'd1);
            chk("fill_ready", 32'(cmd_ready_o), 32'd0);
        end
        @(negedge clk);
        chk("done_pulse", 32'(done_o), 32'd1);
        chk("done_wr_en", 32'(wr_en_o), 32'd0);
        chk("done_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk("done_cleared", 32'(done_o), 32'd0);
        chk("back_ready", 32'(cmd_ready_o), 32'd1);
        chk("back_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic expect_reject();
        @(negedge clk);
        chk("rej_busy_t1", 32'(busy_o), 32'd1);
        chk("rej_err_t1", 32'(err_o), 32'd0);
        chk("rej_ready_t1", 32'(cmd_ready_o), 32'd0);
        @(negedge clk);
        chk("rej_err_t2", 32'(err_o), 32'd1);
        chk("rej_ready_t2", 32'(cmd_ready_o), 32'd1);
        chk("rej_busy_t2", 32'(busy_o), 32'd0);
        chk("rej_wr_en", 32'(wr_en_o), 32'd0);
        @(negedge clk);
        chk("rej_err_t3", 32'(err_o), 32'd0);
        chk("rej_done", 32'(done_o), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_x0_i    = '0;
        cmd_y0_i    = '0;
        cmd_x1_i    = '0;
        cmd_y1_i    = '0;
        cmd_color_i = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_low", 32'(cmd_ready_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_wr_en", 32'(wr_en_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready_o), 32'd1);

        // 3x2 rectangle
        push_rect(10, 20, 12, 21, 'hF00);
        send(10, 20, 12, 21, 'hF00);
        expect_fill(6);
        chk("sb_empty_rect", 32'(exp_addr_q.size()), 32'd0);

        // Single bottom-right pixel
        push_rect(639, 479, 639, 479, 'h0F0);
        send(639, 479, 639, 479, 'h0F0);
        expect_fill(1);
        chk("sb_empty_pixel", 32'(exp_addr_q.size()), 32'd0);

        // Rejected commands
        send(5, 0, 4, 0, 'h123);
        expect_reject();
        send(0, 0, 3, 480, 'h123);
        expect_reject();
        send(0, 0, 640, 3, 'h123);
        expect_reject();

        // Bottom ten full rows with a second command held pending meanwhile
        push_rect(0, 470, 639, 479, 'h5A5);
        send(0, 470, 639, 479, 'h5A5);
        push_rect(1, 1, 2, 1, 'h00F);
        drive_cmd(1, 1, 2, 1, 'h00F);
        expect_fill(6400);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        cmd_x0_i    = 10'd7;
        cmd_color_i = 12'hFFF;
        expect_fill(2);
        chk("sb_empty_held", 32'(exp_addr_q.size()), 32'd0);

        // Reset at the 100th write of a full-screen fill
        push_rect(0, 0, 99, 0, 'hABC);
        send(0, 0, 639, 479, 'hABC);
        @(negedge clk);
        chk("fs_check_busy", 32'(busy_o), 32'd1);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("fs_wr_en", 32'(wr_en_o), 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_wr_en", 32'(wr_en_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_err", 32'(err_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_ready_in_rst", 32'(cmd_ready_o), 32'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_abort_done", 32'(done_o), 32'd0);
            chk("post_abort_err", 32'(err_o), 32'd0);
        end
        chk("sb_empty_abort", 32'(exp_addr_q.size()), 32'd0);
        push_rect(0, 0, 0, 0, 'h777);
        send(0, 0, 0, 0, 'h777);
        expect_fill(1);
        chk("sb_empty_final", 32'(exp_addr_q.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
